s2a_burst_writer: RTL and testbench
===================================

Name: s2a_burst_writer

Overview:
- Parametrised single-clock successor to the stream-to-AXI write path.
- Accepts a sample stream (Sin/Ien), buffers it in an internal FWFT FIFO, and writes it as AXI3 INCR bursts into a ring buffer in DDR (ibase, isize).
- Generalised in data width and burst length. Adds overflow counting, write-response checking and sync-driven ring restart.
- Sits between the sample source and the HP AXI write port. Read channels are out of scope.

Parameters:
- DW, 32, data width in bits; legal values 32 or 64.
- BURST_LEN, 16, beats per burst; 1..16.
- FIFO_AW, 6, FIFO address bits; depth 2^FIFO_AW, which must be >= 2*BURST_LEN.
- SIZE_W, 18, width of isize/iacnt, in bursts.

Ports:
- AXI_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- sync  in  1  pulse; restart ring at ibase.
- Sin  in  DW  sample data.
- Ien  in  1  sample valid; no backpressure.
- ibase  in  32  ring base byte address; aligned to BURST_LEN*DW/8.
- isize  in  SIZE_W  ring size in bursts; 0 = disabled.
- iacnt  out  SIZE_W  index of the next burst within the ring.
- ibcnt  out  32  total completed bursts.
- ovf_cnt  out  16  dropped samples, saturating.
- err  out  1  sticky; set on a non-OKAY bresp.
- AXI_awaddr out 32; AXI_awlen out 4; AXI_awsize out 3; AXI_awburst out 2; AXI_awvalid out 1; AXI_awready in 1.
- AXI_wdata out DW; AXI_wstrb out DW/8; AXI_wlast out 1; AXI_wvalid out 1; AXI_wready in 1.
- AXI_bresp in 2; AXI_bvalid in 1; AXI_bready out 1.

Behaviour:
- Constant outputs:
  - awlen = BURST_LEN-1.
  - awsize = log2(DW/8).
  - awburst = 2'b01.
  - wstrb = all ones.
- Reset (rst low, asynchronous) clears: FIFO; iacnt=0; ibcnt=0; ovf_cnt=0; err=0; awvalid=wvalid=wlast=bready=0; state IDLE.
- FIFO write: on a cycle with Ien=1:
  - not full: push Sin;
  - full: drop Sin and increment ovf_cnt, saturating at 16'hFFFF.
  - A push and a pop in the same cycle are both honoured; fill level is unchanged.
- awaddr = ibase + iacnt*(BURST_LEN*DW/8), computed modulo 2^32 and registered at the IDLE->ADDR transition.
- State machine:
  - IDLE -> ADDR when fill >= BURST_LEN, isize != 0 and no flush is pending. awvalid rises the cycle after the condition holds.
  - ADDR: awvalid held with a stable awaddr until awready. On the handshake: awvalid=0, go to DATA.
  - DATA: wvalid=1; wdata = FIFO head (FWFT). Pop on each wvalid&wready. A 4-bit beat counter drives wlast=1 on beat BURST_LEN-1. On the final handshake: wvalid=0, go to RESP. A wready stall holds wdata/wlast stable.
  - RESP: bready=1 until bvalid. On the handshake:
    - ibcnt+1 (wraps at 2^32);
    - iacnt = (iacnt+1 == isize) ? 0 : iacnt+1;
    - err |= (bresp != 2'b00);
    - go to IDLE.
- A burst is never started with fewer than BURST_LEN entries, so W never underflows.
- sync:
  - In IDLE: acts the next cycle. Flushes the FIFO and sets iacnt=0, err=0. Samples with Ien in the same cycle as the flush are discarded, and are not counted in ovf_cnt.
  - Mid-burst (ADDR/DATA/RESP): latched as flush-pending. The burst completes normally, then the flush executes in IDLE instead of the iacnt advance. ibcnt still increments.
  - ibcnt and ovf_cnt are never cleared by sync.
- isize changed mid-run: takes effect at the next wrap compare. If iacnt >= the new isize, iacnt wraps to 0 at the next B handshake.
- Only one burst is outstanding. AW always precedes W for the same burst.

Test Plan:
1. Reset, isize=4, ibase=0x1000_0000, DW=32, BURST_LEN=16, AXI slave always ready; feed 64 consecutive samples 0..63 -> 4 bursts at awaddr 0x1000_0000, 0x1000_0040, 0x1000_0080, 0x1000_00C0; data in order; wlast on beats 15/31/47/63; ibcnt=4; iacnt=0 (wrapped).
2. Continue with 16 more samples -> awaddr returns to 0x1000_0000; ibcnt=5; iacnt=1.
3. Hold awready=0 and wready=0 while driving Ien every cycle for 100 cycles, FIFO_AW=6 -> FIFO fills at 64 entries; ovf_cnt=36; no AXI handshake; awvalid and awaddr stay stable.
4. Assert sync during beat 5 of a burst -> burst finishes all 16 beats; after the B handshake the FIFO is empty, iacnt=0 and ibcnt has incremented; the next burst uses awaddr=ibase.
5. Return bresp=2'b10 on one burst -> err=1 and stays 1 through later OKAY responses; a following sync clears it.
6. DW=64, BURST_LEN=8 build: 16 samples -> 2 bursts; awsize=3; awlen=7; address step 0x40; wstrb=8'hFF.

Source files
------------

// File: rtl/s2a_burst_writer.sv
// rtl/s2a_burst_writer.sv - stream-to-AXI3 burst writer into a DDR ring buffer
// Samples are buffered in a FWFT FIFO and emitted as fixed-length INCR bursts, one outstanding.
module s2a_burst_writer #(
  parameter int DW        = 32,
  parameter int BURST_LEN = 16,
  parameter int FIFO_AW   = 6,
  parameter int SIZE_W    = 18
) (
  input  logic              AXI_clk,
  input  logic              rst,
  input  logic              sync,
  input  logic [DW-1:0]     Sin,
  input  logic              Ien,
  input  logic [31:0]       ibase,
  input  logic [SIZE_W-1:0] isize,
  output logic [SIZE_W-1:0] iacnt,
  output logic [31:0]       ibcnt,
  output logic [15:0]       ovf_cnt,
  output logic              err,
  output logic [31:0]       AXI_awaddr,
  output logic [3:0]        AXI_awlen,
  output logic [2:0]        AXI_awsize,
  output logic [1:0]        AXI_awburst,
  output logic              AXI_awvalid,
  input  logic              AXI_awready,
  output logic [DW-1:0]     AXI_wdata,
  output logic [DW/8-1:0]   AXI_wstrb,
  output logic              AXI_wlast,
  output logic              AXI_wvalid,
  input  logic              AXI_wready,
  input  logic [1:0]        AXI_bresp,
  input  logic              AXI_bvalid,
  output logic              AXI_bready
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BYTES_PER_BURST = BURST_LEN * DW / 8;
  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t              state_q;
  logic [DW-1:0]       mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [SIZE_W-1:0]   iacnt_q;
  logic [SIZE_W:0]     iacnt_inc;
  logic [31:0]         ibcnt_q, awaddr_q;
  logic [15:0]         ovf_q;
  logic [3:0]          beat_q;
  logic                err_q, flush_pend_q;
  logic                awvalid_q, wvalid_q, wlast_q, bready_q;
  logic                flush, full, push, drop, pop;

  // A pending flush only executes once the FSM is back in IDLE.
  assign flush = (state_q == IDLE) && flush_pend_q;
  assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign push  = Ien && !full && !flush;
  assign drop  = Ien && full && !flush;
  assign pop   = (state_q == DATA) && AXI_wready;
  assign iacnt_inc = {1'b0, iacnt_q} + (SIZE_W+1)'(1);

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (push) count_d = count_d + CNT_ONE;
      if (pop)  count_d = count_d - CNT_ONE;
    end
  end

  always_ff @(posedge AXI_clk) begin
    if (push) mem_q[wr_ptr_q] <= Sin;
  end

  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      iacnt_q      <= '0;
      ibcnt_q      <= '0;
      ovf_q        <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      beat_q       <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      if (flush) flush_pend_q <= 1'b0;
      if (sync)  flush_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (flush) begin
            iacnt_q <= '0;
            err_q   <= 1'b0;
          end else if (count_q >= (FIFO_AW+1)'(BURST_LEN) && isize != '0) begin
            awaddr_q  <= ibase + 32'(iacnt_q) * 32'(BYTES_PER_BURST);
            awvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (AXI_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (BURST_LEN == 1);
            beat_q    <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (AXI_wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= RESP;
            end else begin
              beat_q  <= beat_q + 4'd1;
              wlast_q <= ((beat_q + 4'd1) == LAST_BEAT);
            end
          end
        end
        RESP: begin
          if (AXI_bvalid) begin
            bready_q <= 1'b0;
            ibcnt_q  <= ibcnt_q + 32'd1;
            // Using >= lets a shrunken isize pull an out-of-range index back to 0.
            if (!flush_pend_q)
              iacnt_q <= (iacnt_inc >= {1'b0, isize}) ? '0 : iacnt_inc[SIZE_W-1:0];
            err_q   <= err_q | (AXI_bresp != 2'b00);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign iacnt       = iacnt_q;
  assign ibcnt       = ibcnt_q;
  assign ovf_cnt     = ovf_q;
  assign err         = err_q;
  assign AXI_awaddr  = awaddr_q;
  assign AXI_awlen   = LAST_BEAT;
  assign AXI_awsize  = (DW == 64) ? 3'd3 : 3'd2;
  assign AXI_awburst = 2'b01;
  assign AXI_awvalid = awvalid_q;
  assign AXI_wdata   = mem_q[rd_ptr_q];
  assign AXI_wstrb   = '1;
  assign AXI_wlast   = wlast_q;
  assign AXI_wvalid  = wvalid_q;
  assign AXI_bready  = bready_q;

endmodule

// File: tb/tb_s2a_burst_writer.sv
// tb/tb_s2a_burst_writer.sv - directed bench for s2a_burst_writer (32-bit and 64-bit builds)
module tb_s2a_burst_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync;
  logic [31:0] sin;
  logic        ien;
  logic [31:0] ibase;
  logic [17:0] isize;
  logic [17:0] iacnt;
  logic [31:0] ibcnt;
  logic [15:0] ovf_cnt;
  logic        err;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  logic        sync64;
  logic [63:0] sin64;
  logic        ien64;
  logic [31:0] ibase64;
  logic [17:0] isize64;
  logic [17:0] iacnt64;
  logic [31:0] ibcnt64;
  logic [15:0] ovf64;
  logic        err64;
  logic [31:0] awaddr64;
  logic [3:0]  awlen64;
  logic [2:0]  awsize64;
  logic [1:0]  awburst64;
  logic        awvalid64;
  logic [63:0] wdata64;
  logic [7:0]  wstrb64;
  logic        wlast64, wvalid64, bready64;

  int checks = 0;
  int failures = 0;

  logic [31:0] aw_q[$];
  logic [31:0] wd_q[$];
  logic        wl_q[$];
  logic [31:0] aw64_q[$];
  logic [63:0] wd64_q[$];

  always #5 clk = ~clk;

  s2a_burst_writer #(.DW(32), .BURST_LEN(16), .FIFO_AW(6), .SIZE_W(18)) dut (
    .AXI_clk(clk), .rst(rst), .sync(sync), .Sin(sin), .Ien(ien),
    .ibase(ibase), .isize(isize), .iacnt(iacnt), .ibcnt(ibcnt),
    .ovf_cnt(ovf_cnt), .err(err),
    .AXI_awaddr(awaddr), .AXI_awlen(awlen), .AXI_awsize(awsize),
    .AXI_awburst(awburst), .AXI_awvalid(awvalid), .AXI_awready(awready),
    .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wlast(wlast),
    .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready)
  );

  s2a_burst_writer #(.DW(64), .BURST_LEN(8), .FIFO_AW(6), .SIZE_W(18)) dut64 (
    .AXI_clk(clk), .rst(rst), .sync(sync64), .Sin(sin64), .Ien(ien64),
    .ibase(ibase64), .isize(isize64), .iacnt(iacnt64), .ibcnt(ibcnt64),
    .ovf_cnt(ovf64), .err(err64),
    .AXI_awaddr(awaddr64), .AXI_awlen(awlen64), .AXI_awsize(awsize64),
    .AXI_awburst(awburst64), .AXI_awvalid(awvalid64), .AXI_awready(1'b1),
    .AXI_wdata(wdata64), .AXI_wstrb(wstrb64), .AXI_wlast(wlast64),
    .AXI_wvalid(wvalid64), .AXI_wready(1'b1),
    .AXI_bresp(2'b00), .AXI_bvalid(1'b1), .AXI_bready(bready64)
  );

  always @(posedge clk) begin
    if (awvalid && awready) aw_q.push_back(awaddr);
    if (wvalid && wready) begin
      wd_q.push_back(wdata);
      wl_q.push_back(wlast);
    end
    if (awvalid64) aw64_q.push_back(awaddr64);
    if (wvalid64) wd64_q.push_back(wdata64);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      sin = base + 32'(i);
      ien = 1'b1;
      @(posedge clk); #1;
    end
    ien = 1'b0;
  endtask

  task automatic wait_bcnt(input string tag, input logic [31:0] target);
    for (int i = 0; i < 2000 && ibcnt !== target; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, ibcnt, target);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; sync = 1'b0; sin = '0; ien = 1'b0;
    ibase = 32'h1000_0000; isize = 18'd4;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    sync64 = 1'b0; sin64 = '0; ien64 = 1'b0; ibase64 = 32'h2000_0000; isize64 = 18'd8;
    idle(3);
    chk("rst_iacnt", iacnt, 0);
    chk("rst_ibcnt", ibcnt, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_valids", {awvalid, wvalid, wlast, bready}, 4'b0000);
    rst = 1'b1;
    idle(1);
    chk("const_awlen", awlen, 4'd15);
    chk("const_awsize", awsize, 3'd2);
    chk("const_awburst", awburst, 2'b01);
    chk("const_wstrb", wstrb, 4'hF);

    // Four bursts fill the 4-entry ring and wrap iacnt back to 0.
    feed(64, 32'd0);
    wait_bcnt("t1_ibcnt", 32'd4);
    chk("t1_iacnt", iacnt, 0);
    chk("t1_aw0", aw_q[0], 32'h1000_0000);
    chk("t1_aw1", aw_q[1], 32'h1000_0040);
    chk("t1_aw2", aw_q[2], 32'h1000_0080);
    chk("t1_aw3", aw_q[3], 32'h1000_00C0);
    begin
      int bad_d = 0, bad_l = 0;
      for (int i = 0; i < 64; i++) begin
        if (wd_q[i] !== 32'(i)) bad_d++;
        if (wl_q[i] !== (i % 16 == 15)) bad_l++;
      end
      chk("t1_data_errs", bad_d, 0);
      chk("t1_wlast_errs", bad_l, 0);
    end

    feed(16, 32'd64);
    wait_bcnt("t2_ibcnt", 32'd5);
    chk("t2_iacnt", iacnt, 1);
    chk("t2_aw4", aw_q[4], 32'h1000_0000);
    chk("t2_d79", wd_q[79], 32'd79);

    // Stalled slave: FIFO saturates at 64, remaining 36 samples are dropped.
    awready = 1'b0; wready = 1'b0;
    feed(100, 32'h100);
    chk("t3_ovf", ovf_cnt, 16'd36);
    chk("t3_awvalid", awvalid, 1);
    chk("t3_awaddr", awaddr, 32'h1000_0040);
    chk("t3_aw_count", aw_q.size(), 5);
    chk("t3_w_count", wd_q.size(), 80);
    awready = 1'b1; wready = 1'b1;
    wait_bcnt("t3_drain_ibcnt", 32'd9);
    chk("t3_iacnt", iacnt, 1);
    chk("t3_aw8", aw_q[8], 32'h1000_0000);
    chk("t3_d_first", wd_q[80], 32'h100);
    chk("t3_d_last", wd_q[143], 32'h13F);

    // Sync mid-burst: burst completes, then flush discards the 4 leftover samples.
    fork
      feed(20, 32'h200);
      begin
        for (int i = 0; i < 200 && wd_q.size() != 149; i++) begin
          @(posedge clk); #1;
        end
        chk("t4_reach_beat5", wd_q.size(), 149);
        sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
      end
    join
    wait_bcnt("t4_ibcnt", 32'd10);
    idle(3);
    chk("t4_iacnt", iacnt, 0);
    chk("t4_aw9", aw_q[9], 32'h1000_0040);
    chk("t4_beats", wd_q.size(), 160);
    chk("t4_wlast", wl_q[159], 1);
    chk("t4_d_last", wd_q[159], 32'h20F);
    feed(15, 32'h300);
    idle(5);
    chk("t4_no_start", awvalid, 0);
    feed(1, 32'h30F);
    wait_bcnt("t4_next_ibcnt", 32'd11);
    chk("t4_aw10", aw_q[10], 32'h1000_0000);
    chk("t4_d_new", wd_q[160], 32'h300);

    // SLVERR is sticky until a sync.
    bresp = 2'b10;
    feed(16, 32'h400);
    wait_bcnt("t5_ibcnt_a", 32'd12);
    chk("t5_err_set", err, 1);
    bresp = 2'b00;
    feed(16, 32'h500);
    wait_bcnt("t5_ibcnt_b", 32'd13);
    chk("t5_err_sticky", err, 1);
    chk("t5_iacnt", iacnt, 3);
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    idle(3);
    chk("t5_err_clr", err, 0);
    chk("t5_iacnt_clr", iacnt, 0);
    chk("t5_ibcnt_kept", ibcnt, 32'd13);
    chk("t5_ovf_kept", ovf_cnt, 16'd36);

    // isize=0 disables; shrinking isize below iacnt wraps at the next response.
    isize = 18'd0;
    feed(16, 32'h600);
    idle(5);
    chk("t6_disabled", awvalid, 0);
    isize = 18'd4;
    wait_bcnt("t6_ibcnt", 32'd14);
    chk("t6_aw", aw_q[13], 32'h1000_0000);
    isize = 18'd1;
    feed(16, 32'h700);
    wait_bcnt("t6_shrink_ibcnt", 32'd15);
    chk("t6_shrink_aw", aw_q[14], 32'h1000_0040);
    chk("t6_shrink_iacnt", iacnt, 0);

    // 64-bit, 8-beat build.
    chk("t7_awsize", awsize64, 3'd3);
    chk("t7_awlen", awlen64, 4'd7);
    chk("t7_wstrb", wstrb64, 8'hFF);
    for (int i = 0; i < 16; i++) begin
      sin64 = 64'hA000_0000_0000_0000 + 64'(i);
      ien64 = 1'b1;
      @(posedge clk); #1;
    end
    ien64 = 1'b0;
    for (int i = 0; i < 2000 && ibcnt64 !== 32'd2; i++) begin
      @(posedge clk); #1;
    end
    chk("t7_ibcnt", ibcnt64, 32'd2);
    chk("t7_iacnt", iacnt64, 2);
    chk("t7_aw0", aw64_q[0], 32'h2000_0000);
    chk("t7_aw1", aw64_q[1], 32'h2000_0040);
    chk("t7_beats", wd64_q.size(), 16);
    chk("t7_d_last", wd64_q[15], 64'hA000_0000_0000_000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
